// File: rtl/sincos_sweep_aligner.sv
// -----------------------------------------------------------------------------
// sincos_sweep_aligner
//   Generates a programmable phase sweep for a sin/cos style core and pairs
//   every result the core returns with the {tag, phase} of the sample that
//   produced it. An in-order FIFO holds the outstanding samples, so the core's
//   latency does not need to be known. Results with no outstanding sample and
//   a core that stops answering are reported on sticky error flags.
//
// Ports
//   clk, resetn            clock, async active-low reset
//   start_i                launch a sweep (IDLE only); config below is latched
//   stop_i                 end issuing early (RUN only)
//   mode_i                 0 single sweep, 1 continuous
//   phase_start_i/step_i   first phase and increment (mod 2^PHASE_W)
//   count_i                samples per sweep
//   dut_valid_o/phase_o    registered issue strobe / phase to the core
//   dut_valid_i/result_i   result strobe / data from the core
//   out_valid_o            aligned word valid; tag/phase/result below
//   out_tag_o/phase_o/result_o
//   busy_o                 not IDLE
//   done_o                 one-cycle pulse at sweep completion
//   err_orphan_o           sticky: result arrived with nothing outstanding
//   err_timeout_o          sticky: drain gave up waiting for results
// -----------------------------------------------------------------------------
module sincos_sweep_aligner #(
  parameter int PHASE_W    = 32,
  parameter int RESULT_W   = 32,
  parameter int TAG_W      = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                mode_i,
  input  logic [PHASE_W-1:0]  phase_start_i,
  input  logic [PHASE_W-1:0]  phase_step_i,
  input  logic [CNT_W-1:0]    count_i,
  output logic                dut_valid_o,
  output logic [PHASE_W-1:0]  dut_phase_o,
  input  logic                dut_valid_i,
  input  logic [RESULT_W-1:0] dut_result_i,
  output logic                out_valid_o,
  output logic [TAG_W-1:0]    out_tag_o,
  output logic [PHASE_W-1:0]  out_phase_o,
  output logic [RESULT_W-1:0] out_result_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_orphan_o,
  output logic                err_timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [PHASE_W-1:0] phase;
  } entry_t;

  state_t               r_state, w_state_nxt;
  logic                 r_mode;
  logic [PHASE_W-1:0]   r_start, r_step, r_phase_acc;
  logic [CNT_W-1:0]     r_count, r_issued;
  logic [TAG_W-1:0]     r_tag;

  entry_t               r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_fcnt;
  logic [TW-1:0]        r_to_cnt;

  logic                 r_dut_valid;
  logic [PHASE_W-1:0]   r_dut_phase;
  logic                 r_out_valid;
  logic [TAG_W-1:0]     r_out_tag;
  logic [PHASE_W-1:0]   r_out_phase;
  logic [RESULT_W-1:0]  r_out_result;
  logic                 r_err_orphan, r_err_timeout;

  logic w_full, w_empty, w_more, w_issue, w_last, w_pop, w_orphan, w_to_hit;
  entry_t w_head;

  // Full/empty come from the registered count, so a pop this cycle only
  // frees a slot for the following cycle.
  assign w_full   = (r_fcnt == FULL_C);
  assign w_empty  = (r_fcnt == '0);
  assign w_more   = (r_issued != r_count);
  assign w_issue  = (r_state == S_RUN) && !stop_i && w_more && !w_full;
  assign w_last   = w_issue && ((r_issued + CNT_W'(1)) == r_count);
  assign w_pop    = dut_valid_i && !w_empty;
  assign w_orphan = dut_valid_i && w_empty;
  assign w_head   = r_mem[r_rd_ptr];
  // TIMEOUT-th consecutive silent drain cycle with work still outstanding
  assign w_to_hit = (r_state == S_DRAIN) && !w_empty && !dut_valid_i &&
                    (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
      // !w_more only happens here for count==0; otherwise the last issue
      // either wraps (continuous) or moves to DRAIN (single).
      S_RUN:   if (stop_i || !w_more || (w_last && !r_mode)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty || w_to_hit) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample storage carries no reset; occupancy is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (w_issue) r_mem[r_wr_ptr] <= '{tag: r_tag, phase: r_phase_acc};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_start       <= '0;
      r_step        <= '0;
      r_phase_acc   <= '0;
      r_count       <= '0;
      r_issued      <= '0;
      r_tag         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fcnt        <= '0;
      r_to_cnt      <= '0;
      r_dut_valid   <= 1'b0;
      r_dut_phase   <= '0;
      r_out_valid   <= 1'b0;
      r_out_tag     <= '0;
      r_out_phase   <= '0;
      r_out_result  <= '0;
      r_err_orphan  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && start_i) begin
        r_mode      <= mode_i;
        r_start     <= phase_start_i;
        r_step      <= phase_step_i;
        r_count     <= count_i;
        r_phase_acc <= phase_start_i;
        r_issued    <= '0;
      end

      // Tag keeps running across continuous wraps.
      if (w_issue) begin
        r_tag <= r_tag + TAG_W'(1);
        if (w_last && r_mode) begin
          r_phase_acc <= r_start;
          r_issued    <= '0;
        end else begin
          r_phase_acc <= r_phase_acc + r_step;
          r_issued    <= r_issued + CNT_W'(1);
        end
      end

      r_dut_valid <= w_issue;
      if (w_issue) r_dut_phase <= r_phase_acc;

      if (w_issue) r_wr_ptr <= r_wr_ptr + AW'(1);
      // Abort flush: no pop can coincide (no dut_valid_i) and no push
      // happens in DRAIN, so the read pointer simply catches up.
      if (w_to_hit) begin
        r_rd_ptr <= r_wr_ptr;
        r_fcnt   <= '0;
      end else begin
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_fcnt <= r_fcnt + (AW+1)'(w_issue) - (AW+1)'(w_pop);
      end

      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_tag    <= w_head.tag;
        r_out_phase  <= w_head.phase;
        r_out_result <= dut_result_i;
      end

      if (w_orphan) r_err_orphan  <= 1'b1;
      if (w_to_hit) r_err_timeout <= 1'b1;

      if (r_state != S_DRAIN || dut_valid_i || w_to_hit) r_to_cnt <= '0;
      else                                               r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign dut_valid_o   = r_dut_valid;
  assign dut_phase_o   = r_dut_phase;
  assign out_valid_o   = r_out_valid;
  assign out_tag_o     = r_out_tag;
  assign out_phase_o   = r_out_phase;
  assign out_result_o  = r_out_result;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign err_orphan_o  = r_err_orphan;
  assign err_timeout_o = r_err_timeout;

endmodule
